// File: rtl/uart_cfg_pkg.sv
// Shared constants and types for the AWG delay-configuration UART receiver.
// Frame layout is 64 bits, MSB first: header, board ID, channel, delay.
package uart_cfg_pkg;

  localparam logic [31:0] HDR_WRITE    = 32'h0200_2000;
  localparam logic [31:0] HDR_ADDR_RST = 32'h0200_2001;
  localparam logic [3:0]  CH_BCAST     = 4'hF;

  localparam int HDR_MSB = 63;
  localparam int HDR_LSB = 32;
  localparam int BID_MSB = 31;
  localparam int BID_LSB = 28;
  localparam int CH_MSB  = 27;
  localparam int CH_LSB  = 24;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_delay_cfg_if.sv
// Write bus from the configuration receiver to the per-channel delay RAMs.
// Channel 0 occupies the LSBs of each flattened vector.
interface uart_rx_delay_cfg_if #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 11,
  parameter int DELAY_W = 24
);

  logic [NUM_CH-1:0]         wea;
  logic [NUM_CH*ADDR_W-1:0]  waddr;
  logic [NUM_CH*DELAY_W-1:0] wdata;

  modport master (output wea, waddr, wdata);
  modport slave  (input  wea, waddr, wdata);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop input synchroniser plus a mid-bit sampling FSM.
// Emits one-cycle byte-valid or framing-error pulses after the stop sample.
module uart_rx_byte
  import uart_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxb,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       r_sync;
  logic             r_prev;
  rx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_vld, w_vld_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic             w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rxb};
      r_prev  <= w_rx;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_vld   <= w_vld_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // A high line at the start-bit centre is a glitch: drop back to idle quietly.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_vld_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (!w_rx && r_prev) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          w_vld_nxt   = w_rx;
          w_ferr_nxt  = !w_rx;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign o_byte      = r_shift;
  assign o_byte_vld  = r_vld;
  assign o_frame_err = r_ferr;

endmodule

// File: rtl/uart_rx_delay_cfg.sv
// AWG delay-configuration receiver: assembles 64-bit UART frames, filters on board ID
// and drives auto-incrementing write strobes into per-channel delay RAMs.
module uart_rx_delay_cfg
  import uart_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 11,
  parameter int DELAY_W      = 24,
  parameter int TIMEOUT_CLKS = 2000
) (
  input  logic                I_clk_10M,
  input  logic                I_rst_n,
  input  logic                I_rxb,
  input  logic [3:0]          I_board_id,
  uart_rx_delay_cfg_if.master o_wr,
  output logic                O_busy,
  output logic [15:0]         O_frame_cnt,
  output logic [7:0]          O_err_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CLKS - 1);

  logic [7:0]  w_byte;
  logic        w_byte_vld;
  logic        w_frame_err;

  logic [2:0]        r_byte_cnt;
  logic [55:0]       r_frame;
  logic [IDLE_W-1:0] r_idle;
  logic              w_frame_done;
  logic              w_timeout;
  logic [63:0]       w_frame;
  logic [31:0]       w_hdr;
  logic [3:0]        w_bid;
  logic [3:0]        w_ch;

  logic [NUM_CH-1:0] w_sel, w_tgt, w_wr_mask, w_rst_mask;
  logic              w_dec_err, w_dec_acc;

  logic [NUM_CH-1:0]  r_dec_wr, r_dec_rst;
  logic [DELAY_W-1:0] r_dec_data;
  logic               r_dec_acc;

  logic [ADDR_W-1:0]         r_addr [NUM_CH];
  logic [NUM_CH-1:0]         r_wea;
  logic [NUM_CH*ADDR_W-1:0]  r_waddr;
  logic [NUM_CH*DELAY_W-1:0] r_wdata;
  logic [15:0]               r_frame_cnt;
  logic [7:0]                r_err_cnt;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk       (I_clk_10M),
    .i_rst_n     (I_rst_n),
    .i_rxb       (I_rxb),
    .o_byte      (w_byte),
    .o_byte_vld  (w_byte_vld),
    .o_frame_err (w_frame_err)
  );

  assign w_frame_done = w_byte_vld && (r_byte_cnt == 3'd7);
  assign w_frame      = {r_frame, w_byte};
  assign w_hdr        = w_frame[HDR_MSB:HDR_LSB];
  assign w_bid        = w_frame[BID_MSB:BID_LSB];
  assign w_ch         = w_frame[CH_MSB:CH_LSB];
  assign w_timeout    = (r_byte_cnt != 3'd0) && !w_byte_vld && !w_frame_err &&
                        (r_idle == IDLE_LAST);

  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_byte_cnt <= '0;
      r_frame    <= '0;
      r_idle     <= '0;
    end else begin
      if (w_frame_err || w_timeout) begin
        r_byte_cnt <= '0;
      end else if (w_byte_vld) begin
        r_byte_cnt <= r_byte_cnt + 3'd1;
        r_frame    <= {r_frame[47:0], w_byte};
      end
      if (w_byte_vld || w_frame_err || w_timeout || r_byte_cnt == 3'd0) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end

  // Broadcast selects every channel; an empty target means an out-of-range channel.
  always_comb begin
    w_sel      = '0;
    w_tgt      = '0;
    w_wr_mask  = '0;
    w_rst_mask = '0;
    w_dec_err  = 1'b0;
    w_dec_acc  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == 4'(c)) w_sel[c] = 1'b1;
    end
    w_tgt = (w_ch == CH_BCAST) ? '1 : w_sel;
    if (w_frame_done) begin
      if (w_hdr != HDR_WRITE && w_hdr != HDR_ADDR_RST) begin
        w_dec_err = 1'b1;
      end else if (w_bid == I_board_id) begin
        if (w_tgt == '0) begin
          w_dec_err = 1'b1;
        end else begin
          w_dec_acc = 1'b1;
          if (w_hdr == HDR_WRITE) w_wr_mask = w_tgt;
          else                    w_rst_mask = w_tgt;
        end
      end
    end
  end

  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_dec_wr   <= '0;
      r_dec_rst  <= '0;
      r_dec_data <= '0;
      r_dec_acc  <= 1'b0;
    end else begin
      r_dec_wr   <= w_wr_mask;
      r_dec_rst  <= w_rst_mask;
      r_dec_data <= w_frame[DELAY_W-1:0];
      r_dec_acc  <= w_dec_acc;
    end
  end

  // Strobe carries the pre-increment address; the counter advances as the strobe drops.
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_wea   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      for (int c = 0; c < NUM_CH; c++) r_addr[c] <= '0;
    end else begin
      r_wea <= r_dec_wr;
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_dec_wr[c]) begin
          r_waddr[c*ADDR_W +: ADDR_W]   <= r_addr[c];
          r_wdata[c*DELAY_W +: DELAY_W] <= r_dec_data;
        end
        if (r_dec_rst[c])  r_addr[c] <= '0;
        else if (r_wea[c]) r_addr[c] <= r_addr[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (r_dec_acc) r_frame_cnt <= r_frame_cnt + 16'd1;
      if ((w_frame_err || w_timeout || w_dec_err) && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_wr.wea    = r_wea;
  assign o_wr.waddr  = r_waddr;
  assign o_wr.wdata  = r_wdata;
  assign O_busy      = (r_byte_cnt != 3'd0);
  assign O_frame_cnt = r_frame_cnt;
  assign O_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_delay_cfg.sv
// Directed bench for uart_rx_delay_cfg: drives UART frames bit by bit and checks
// strobes, addresses, data, counters and strobe timing against hand-computed values.
module tb_uart_rx_delay_cfg;

  localparam logic [31:0] HDR_W = 32'h0200_2000;
  localparam logic [31:0] HDR_R = 32'h0200_2001;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        rxb = 1'b1;
  logic [3:0]  boardId = 4'hE;
  logic        busy;
  logic [15:0] frameCnt;
  logic [7:0]  errCnt;

  int vecCnt = 0;
  int missCnt = 0;
  int strobeCnt = 0;
  int s0;

  uart_rx_delay_cfg_if #(.NUM_CH(4), .ADDR_W(11), .DELAY_W(24)) wrBus ();

  uart_rx_delay_cfg #(
    .CLKS_PER_BIT(10), .NUM_CH(4), .ADDR_W(11), .DELAY_W(24), .TIMEOUT_CLKS(2000)
  ) dut (
    .I_clk_10M   (clk),
    .I_rst_n     (rstN),
    .I_rxb       (rxb),
    .I_board_id  (boardId),
    .o_wr        (wrBus),
    .O_busy      (busy),
    .O_frame_cnt (frameCnt),
    .O_err_cnt   (errCnt)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (wrBus.wea != 4'b0) strobeCnt++;
  end

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      missCnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called 1 ns after a rising edge; each bit is held for ten rising edges.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int stopEdges);
    rxb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxb = b[i];
      repeat (10) @(posedge clk);
      #1;
    end
    rxb = stopBit;
    repeat (stopEdges) @(posedge clk);
    #1;
    rxb = 1'b1;
  endtask

  // Stop of the last byte is sampled on its 98th edge, so the strobe is due on edge 100.
  task automatic sendFrame(input string tag, input logic [63:0] f, input logic [3:0] expWea);
    for (int i = 7; i >= 1; i--) applyStimulus(f[i*8 +: 8], 1'b1, 10);
    applyStimulus(f[7:0], 1'b1, 9);
    checkOutput({tag, "_pre"}, wrBus.wea, 96'(4'b0));
    @(posedge clk);
    #1;
    checkOutput({tag, "_wea"}, wrBus.wea, 96'(expWea));
    @(posedge clk);
    #1;
    checkOutput({tag, "_drop"}, wrBus.wea, 96'(4'b0));
  endtask

  initial begin
    #20 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wea", wrBus.wea, 0);
    checkOutput("rst_waddr", wrBus.waddr, 0);
    checkOutput("rst_wdata", wrBus.wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame", frameCnt, 0);
    checkOutput("rst_err", errCnt, 0);
    rstN = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // One write per channel
    sendFrame("w0", {HDR_W, 4'hE, 4'h0, 24'h00000A}, 4'b0001);
    checkOutput("w0_addr", wrBus.waddr[0 +: 11], 0);
    checkOutput("w0_data", wrBus.wdata[0 +: 24], 24'd10);
    sendFrame("w1", {HDR_W, 4'hE, 4'h1, 24'h000014}, 4'b0010);
    checkOutput("w1_addr", wrBus.waddr[11 +: 11], 0);
    checkOutput("w1_data", wrBus.wdata[24 +: 24], 24'd20);
    sendFrame("w2", {HDR_W, 4'hE, 4'h2, 24'h00001E}, 4'b0100);
    checkOutput("w2_addr", wrBus.waddr[22 +: 11], 0);
    checkOutput("w2_data", wrBus.wdata[48 +: 24], 24'd30);
    sendFrame("w3", {HDR_W, 4'hE, 4'h3, 24'h000028}, 4'b1000);
    checkOutput("w3_addr", wrBus.waddr[33 +: 11], 0);
    checkOutput("w3_data", wrBus.wdata[72 +: 24], 24'd40);
    checkOutput("t1_frame", frameCnt, 4);
    checkOutput("t1_err", errCnt, 0);

    // Address reset: broadcast clear, then ch1 increments and a single-channel clear
    sendFrame("rall", {HDR_R, 4'hE, 4'hF, 24'h000000}, 4'b0000);
    checkOutput("rall_frame", frameCnt, 5);
    sendFrame("a5", {HDR_W, 4'hE, 4'h1, 24'h000005}, 4'b0010);
    checkOutput("a5_addr", wrBus.waddr[11 +: 11], 0);
    checkOutput("a5_data", wrBus.wdata[24 +: 24], 24'd5);
    sendFrame("b5", {HDR_W, 4'hE, 4'h1, 24'h000005}, 4'b0010);
    checkOutput("b5_addr", wrBus.waddr[11 +: 11], 1);
    sendFrame("r1", {HDR_R, 4'hE, 4'h1, 24'h000000}, 4'b0000);
    sendFrame("c7", {HDR_W, 4'hE, 4'h1, 24'h000007}, 4'b0010);
    checkOutput("c7_addr", wrBus.waddr[11 +: 11], 0);
    checkOutput("c7_data", wrBus.wdata[24 +: 24], 24'd7);
    checkOutput("t2_frame", frameCnt, 9);

    // Broadcast write: ch1 counter is 1, the others 0
    sendFrame("bc", {HDR_W, 4'hE, 4'hF, 24'h0000FF}, 4'b1111);
    checkOutput("bc_addr", wrBus.waddr, 44'h000_0000_0800);
    checkOutput("bc_data", wrBus.wdata, 96'h0000FF_0000FF_0000FF_0000FF);
    checkOutput("bc_frame", frameCnt, 10);

    // Foreign board is silent; channel 5 is an error
    s0 = strobeCnt;
    sendFrame("bid", {HDR_W, 4'h3, 4'h0, 24'h000011}, 4'b0000);
    checkOutput("bid_strobes", strobeCnt - s0, 0);
    checkOutput("bid_frame", frameCnt, 10);
    checkOutput("bid_err", errCnt, 0);
    sendFrame("ch5", {HDR_W, 4'hE, 4'h5, 24'h000011}, 4'b0000);
    checkOutput("ch5_strobes", strobeCnt - s0, 0);
    checkOutput("ch5_err", errCnt, 1);
    checkOutput("ch5_frame", frameCnt, 10);

    // Inter-byte timeout
    applyStimulus(8'h02, 1'b1, 10);
    applyStimulus(8'h00, 1'b1, 10);
    applyStimulus(8'h20, 1'b1, 10);
    checkOutput("to_busy", busy, 1);
    repeat (1800) @(posedge clk);
    #1;
    checkOutput("to_hold", busy, 1);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("to_idle", busy, 0);
    checkOutput("to_err", errCnt, 2);
    sendFrame("to_next", {HDR_W, 4'hE, 4'h2, 24'h123456}, 4'b0100);
    checkOutput("to_next_addr", wrBus.waddr[22 +: 11], 1);
    checkOutput("to_next_data", wrBus.wdata[48 +: 24], 24'h123456);
    checkOutput("to_next_frame", frameCnt, 11);

    // Framing error on the fourth byte
    s0 = strobeCnt;
    applyStimulus(8'h02, 1'b1, 10);
    applyStimulus(8'h00, 1'b1, 10);
    applyStimulus(8'h20, 1'b1, 10);
    applyStimulus(8'h00, 1'b0, 10);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("fe_busy", busy, 0);
    checkOutput("fe_err", errCnt, 3);
    checkOutput("fe_strobes", strobeCnt - s0, 0);

    // Reset in the middle of byte six
    for (int i = 0; i < 5; i++) applyStimulus(8'hA5, 1'b1, 10);
    rxb = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    rstN = 1'b0;
    #10;
    checkOutput("mr_wea", wrBus.wea, 0);
    checkOutput("mr_waddr", wrBus.waddr, 0);
    checkOutput("mr_wdata", wrBus.wdata, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_frame", frameCnt, 0);
    checkOutput("mr_err", errCnt, 0);
    rxb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    s0 = strobeCnt;
    repeat (300) @(posedge clk);
    #1;
    checkOutput("mr_strobes", strobeCnt - s0, 0);
    sendFrame("mr_next", {HDR_W, 4'hE, 4'h0, 24'h000055}, 4'b0001);
    checkOutput("mr_next_addr", wrBus.waddr[0 +: 11], 0);
    checkOutput("mr_next_data", wrBus.wdata[0 +: 24], 24'h55);
    checkOutput("mr_next_frame", frameCnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
